// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA pixel-generation stage.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int DIM_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/raster_counter.sv
// 2-D raster counter: inner advances every enabled cycle, outer on inner wrap.
module raster_counter #(
    parameter int INNER_W = 8,
    parameter int OUTER_W = 7
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               en,
    input  logic [INNER_W-1:0] inner_max,
    input  logic [OUTER_W-1:0] outer_max,
    output logic [INNER_W-1:0] inner,
    output logic [OUTER_W-1:0] outer,
    output logic               last
);

    logic [INNER_W-1:0] inner_reg;
    logic [OUTER_W-1:0] outer_reg;
    logic               inner_wrap;
    logic               outer_wrap;

    assign inner_wrap = (inner_reg == inner_max);
    assign outer_wrap = (outer_reg == outer_max);

    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            inner_reg <= '0;
            outer_reg <= '0;
        end else if (en) begin
            if (inner_wrap) begin
                inner_reg <= '0;
                outer_reg <= outer_wrap ? '0 : outer_reg + 1'b1;
            end else begin
                inner_reg <= inner_reg + 1'b1;
            end
        end
    end

    assign inner = inner_reg;
    assign outer = outer_reg;
    assign last  = inner_wrap && outer_wrap;

endmodule

// File: rtl/vga_box_drawer.sv
// Rasterises a filled, clipped box or a full-frame clear, one registered pixel per clock.
module vga_box_drawer #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [4:0] w,
    input  logic [4:0] h,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    import vga_pkg::*;

    draw_state_t state_reg, state_next;

    logic [X_W-1:0]      x0_reg;
    logic [Y_W-1:0]      y0_reg;
    logic [DIM_W-1:0]    w_reg;
    logic [DIM_W-1:0]    h_reg;
    logic [COLOUR_W-1:0] colour_lat_reg;

    logic [X_W-1:0]      x_reg, x_next;
    logic [Y_W-1:0]      y_reg, y_next;
    logic [COLOUR_W-1:0] colour_reg, colour_next;
    logic                plot_reg, plot_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic                accept;
    logic                cnt_load;
    logic                cnt_en;
    logic [X_W-1:0]      inner_max;
    logic [Y_W-1:0]      outer_max;
    logic [X_W-1:0]      dx;
    logic [Y_W-1:0]      dy;
    logic                cnt_last;
    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;
    logic                in_bounds;

    assign accept = (state_reg == IDLE) && (start || clear);

    // One counter serves both scans; limits follow the active state.
    always_comb begin
        if (state_reg == CLEAR) begin
            inner_max = X_W'(SCREEN_W - 1);
            outer_max = Y_W'(SCREEN_H - 1);
        end else begin
            inner_max = {{(X_W - DIM_W){1'b0}}, w_reg} - 1'b1;
            outer_max = {{(Y_W - DIM_W){1'b0}}, h_reg} - 1'b1;
        end
    end

    raster_counter #(
        .INNER_W (X_W),
        .OUTER_W (Y_W)
    ) u_raster_counter (
        .clk       (CLOCK_50),
        .resetn    (resetn),
        .load      (cnt_load),
        .en        (cnt_en),
        .inner_max (inner_max),
        .outer_max (outer_max),
        .inner     (dx),
        .outer     (dy),
        .last      (cnt_last)
    );

    // Widened sums so a box straddling the right/bottom edge is clipped, not wrapped.
    assign x_sum     = {1'b0, x0_reg} + {1'b0, dx};
    assign y_sum     = {1'b0, y0_reg} + {1'b0, dy};
    assign in_bounds = (x_sum < (X_W + 1)'(SCREEN_W)) && (y_sum < (Y_W + 1)'(SCREEN_H));

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            x0_reg         <= '0;
            y0_reg         <= '0;
            w_reg          <= '0;
            h_reg          <= '0;
            colour_lat_reg <= '0;
        end else if (accept) begin
            x0_reg         <= x0;
            y0_reg         <= y0;
            w_reg          <= w;
            h_reg          <= h;
            colour_lat_reg <= colour_in;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        plot_next   = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (clear) begin
                    cnt_load   = 1'b1;
                    state_next = CLEAR;
                end else if (start) begin
                    cnt_load   = 1'b1;
                    state_next = ((w == '0) || (h == '0)) ? DONE : DRAW;
                end
            end
            DRAW: begin
                cnt_en      = 1'b1;
                x_next      = x_sum[X_W-1:0];
                y_next      = y_sum[Y_W-1:0];
                colour_next = colour_lat_reg;
                plot_next   = in_bounds;
                busy_next   = 1'b1;
                if (cnt_last) begin
                    state_next = DONE;
                end
            end
            CLEAR: begin
                cnt_en      = 1'b1;
                x_next      = dx;
                y_next      = dy;
                colour_next = '0;
                plot_next   = 1'b1;
                busy_next   = 1'b1;
                if (cnt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign x      = x_reg;
    assign y      = y_reg;
    assign colour = colour_reg;
    assign plot   = plot_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_vga_box_drawer.sv
// Directed, table-driven bench for vga_box_drawer with hand-computed expectations.
module tb_vga_box_drawer;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       start    = 1'b0;
    logic       clear    = 1'b0;
    logic [7:0] x0       = '0;
    logic [6:0] y0       = '0;
    logic [4:0] w        = '0;
    logic [4:0] h        = '0;
    logic [2:0] colour_in = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    vga_box_drawer dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (start),
        .clear     (clear),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .colour_in (colour_in),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int    x0, y0, w, h, col;
        bit    clr;
        int    exp_done, exp_busy, exp_plots, exp_col;
        int    fx, fy, lx, ly;
    } vec_t;

    vec_t vecs[8];

    int r_done_k, r_busy, r_plots, r_col_err, r_fx, r_fy, r_lx, r_ly;
    int r_busy_at_done, r_done_after;
    int px_x[$];
    int px_y[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Issue one request, then observe until done (bounded); optionally re-pulse start mid-op.
    task automatic run_op(input vec_t v, input int inject_at, input int inj_x0);
        px_x.delete();
        px_y.delete();
        r_done_k = -1; r_busy = 0; r_plots = 0; r_col_err = 0;
        r_fx = -1; r_fy = -1; r_lx = -1; r_ly = -1;
        x0 = 8'(v.x0); y0 = 7'(v.y0); w = 5'(v.w); h = 5'(v.h);
        colour_in = 3'(v.col);
        start = 1'b1;
        clear = v.clr;
        tick();
        start = 1'b0;
        clear = 1'b0;
        for (int k = 1; k <= 20000; k++) begin
            if (k == inject_at) begin
                start = 1'b1;
                x0    = 8'(inj_x0);
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                r_done_k = k;
                break;
            end
            if (busy) r_busy++;
            if (plot) begin
                if (r_plots == 0) begin
                    r_fx = int'(x); r_fy = int'(y);
                end
                r_lx = int'(x); r_ly = int'(y);
                px_x.push_back(int'(x));
                px_y.push_back(int'(y));
                r_plots++;
                if (int'(colour) != v.exp_col) r_col_err++;
            end
        end
        start = 1'b0;
        r_busy_at_done = int'(busy);
        tick();
        r_done_after = int'(done);
        $display("op %s: done_k=%0d busy=%0d plots=%0d first=(%0d,%0d) last=(%0d,%0d)",
                 v.name, r_done_k, r_busy, r_plots, r_fx, r_fy, r_lx, r_ly);
    endtask

    task automatic check_op(input vec_t v);
        check({v.name, " done latency"}, r_done_k, v.exp_done);
        check({v.name, " busy cycles"}, r_busy, v.exp_busy);
        check({v.name, " plot count"}, r_plots, v.exp_plots);
        check({v.name, " colour errors"}, r_col_err, 0);
        check({v.name, " busy at done"}, r_busy_at_done, 0);
        check({v.name, " done width"}, r_done_after, 0);
        if (v.exp_plots > 0) begin
            check({v.name, " first x"}, r_fx, v.fx);
            check({v.name, " first y"}, r_fy, v.fy);
            check({v.name, " last x"}, r_lx, v.lx);
            check({v.name, " last y"}, r_ly, v.ly);
        end
    endtask

    task automatic check_3x2_sequence(input string tag);
        int ex[6];
        int ey[6];
        ex = '{10, 11, 12, 10, 11, 12};
        ey = '{20, 20, 20, 21, 21, 21};
        check({tag, " seq length"}, px_x.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < px_x.size()) begin
                check($sformatf("%s px%0d x", tag, i), px_x[i], ex[i]);
                check($sformatf("%s px%0d y", tag, i), px_y[i], ey[i]);
            end
        end
    endtask

    initial begin
        int stray;

        //           name        x0   y0   w   h  col clr  done   busy   plots  ecol fx   fy   lx   ly
        vecs[0] = '{"box3x2",    10,  20,  3,  2,  5, 0,     7,     6,     6,    5, 10,  20,  12,  21};
        vecs[1] = '{"corner",   158, 118,  4,  3,  2, 0,    13,    12,     4,    2, 158, 118, 159, 119};
        vecs[2] = '{"w0",         0,   7,  0,  7,  6, 0,     1,     0,     0,    6,  0,   0,   0,   0};
        vecs[3] = '{"h0",        40,  40,  5,  0,  1, 0,     1,     0,     0,    1,  0,   0,   0,   0};
        vecs[4] = '{"one",        5,   5,  1,  1,  7, 0,     2,     1,     1,    7,  5,   5,   5,   5};
        vecs[5] = '{"rclip",    150,   0, 31,  1,  3, 0,    32,    31,    10,    3, 150,  0, 159,   0};
        vecs[6] = '{"bclip",      0, 115,  2, 31,  4, 0,    63,    62,    10,    4,  0, 115,   1, 119};
        vecs[7] = '{"clear",     20,  30,  4,  4,  6, 1, 19201, 19200, 19200,    0,  0,   0, 159, 119};

        resetn = 1'b0;
        repeat (3) tick();
        check("reset x", int'(x), 0);
        check("reset y", int'(y), 0);
        check("reset colour", int'(colour), 0);
        check("reset plot", int'(plot), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], 0, 0);
            check_op(vecs[i]);
            if (i == 0) check_3x2_sequence("box3x2");
        end

        // start re-pulsed mid-draw with a new x0 must be ignored
        run_op(vecs[0], 2, 100);
        check_op(vecs[0]);
        check_3x2_sequence("repulse");

        // reset during pixel 3 of a 4x4 draw
        x0 = 8'd30; y0 = 7'd40; w = 5'd4; h = 5'd4; colour_in = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("rst4x4 pixel3 plot", int'(plot), 1);
        check("rst4x4 pixel3 x", int'(x), 33);
        check("rst4x4 pixel3 y", int'(y), 40);
        resetn = 1'b0;
        tick();
        check("midrst x", int'(x), 0);
        check("midrst y", int'(y), 0);
        check("midrst colour", int'(colour), 0);
        check("midrst plot", int'(plot), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        resetn = 1'b1;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (plot || busy || done) stray++;
        end
        check("midrst stray activity", stray, 0);
        $display("op midreset: stray=%0d", stray);

        run_op(vecs[4], 0, 0);
        check_op(vecs[4]);
        run_op(vecs[0], 0, 0);
        check_op(vecs[0]);
        check_3x2_sequence("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_box_drawer.md
# vga_box_drawer

Pixel-generation stage that drives the VGA adapter port group of the DE1-SoC top level (`x`, `y`, `colour`, `plot`). On request it rasterises a filled rectangle, or clears the full 160×120 frame to black, emitting one pixel per clock with a `plot` strobe. Start requests come from the board-level control logic (SW/KEY debouncing). Completion is reported by a `busy` level and a one-cycle `done` pulse.

## Interface
Parameters:
- `SCREEN_W`, 160: visible columns; x ≥ SCREEN_W is off-screen.
- `SCREEN_H`, 120: visible rows; y ≥ SCREEN_H is off-screen.

Ports:
- `CLOCK_50`  in  1  50 MHz system clock; all state updates on its rising edge.
- `resetn`  in  1  one clock; reset is synchronous and active-low.
- `start`  in  1  request box draw; sampled only in IDLE.
- `clear`  in  1  request full-screen clear; sampled only in IDLE.
- `x0`  in  8  box top-left column.
- `y0`  in  7  box top-left row.
- `w`  in  5  box width in pixels, 0..31.
- `h`  in  5  box height in pixels, 0..31.
- `colour_in`  in  3  box colour.
- `x`  out  8  pixel column to VGA adapter.
- `y`  out  7  pixel row to VGA adapter.
- `colour`  out  3  pixel colour.
- `plot`  out  1  pixel write strobe, one cycle per pixel.
- `busy`  out  1  high while a draw/clear is in progress.
- `done`  out  1  one-cycle pulse on completion.

## Operation
- States: IDLE, DRAW, CLEAR, DONE.
- IDLE: `clear`=1 → CLEAR (clear has priority over simultaneous `start`); else `start`=1 → DRAW. On the accepting edge `x0`, `y0`, `w`, `h`, `colour_in` are latched and the pixel counters are zeroed.
- DRAW: counters dx (0..w-1, inner) and dy (0..h-1, outer), raster order. Outputs `x`=x0+dx, `y`=y0+dy, `colour`=latched colour.
- Sums use widened arithmetic: x 9-bit, y 8-bit. Output ports carry the low 8/7 bits.
- Clipping: if the x sum ≥ SCREEN_W or the y sum ≥ SCREEN_H, `plot`=0 for that cycle. The cycle is still consumed, so latency depends only on w and h.
- `w`=0 or `h`=0: DRAW is skipped. FSM goes IDLE → DONE with no `plot` asserted.
- CLEAR: x 0..159 inner, y 0..119 outer, `colour`=0, `plot`=1 every cycle.
- After the last pixel the FSM enters DONE for one cycle, then returns to IDLE.
- `start`/`clear` in any state other than IDLE are ignored. They are not queued.
- Input changes after acceptance have no effect on the operation in progress.

## Timing
- Reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0; state IDLE. All counters and latches are cleared.
- Reset asserted mid-operation: on the next edge all outputs return to reset values and the operation is abandoned. No further `plot` is issued.
- Latency: `start` sampled at edge N → first pixel presented (`busy`=1) after edge N+1.
- Box: pixel k (k = dy·w + dx) is presented after edge N+1+k. `done`=1, `busy`=0 after edge N+1+w·h.
- Degenerate box: `done` after edge N+1, `busy` never asserted.
- Clear: 19200 pixel cycles. `done` after edge N+19201.
- `done` is high for exactly one cycle. A new request is accepted at the earliest on the edge where the FSM is back in IDLE, i.e. the cycle after `done`.
- `x`/`y`/`colour` are registered. Values hold the last pixel while `plot`=0 and are not required to be zero.

## Structure
- Shared package `vga_pkg`:
  - SCREEN_W, SCREEN_H constants.
  - Coordinate width constants (X_W=8, Y_W=7, COLOUR_W=3).
  - State enum typedef `draw_state_t`.
- Sub-module `raster_counter`: parameterised 2-D counter with load, enable, inner/outer limits and a `last` flag. It is used for both box and clear scans, with limits muxed by state.
- Clip comparison and output registers live in `vga_box_drawer`.

## Test plan
- Reset then x0=10, y0=20, w=3, h=2, colour_in=5, pulse `start` → 6 plot cycles, pixel sequence (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 5; `done` one cycle later; `busy` high for exactly 6 cycles.
- x0=158, y0=118, w=4, h=3 → 12 cycles consumed; `plot`=1 only for (158,118),(159,118),(158,119),(159,119); `done` after 12 pixel cycles.
- `clear` and `start` asserted on the same cycle → clear executes: 19200 plots, colour 0, last pixel (159,119), then `done`.
- w=0, h=7, `start` → `done` on the next cycle; `plot` and `busy` never assert.
- `start` re-pulsed mid-draw with new x0 → ignored; the original box completes unchanged.
- `resetn` driven low during pixel 3 of a 4×4 draw → next cycle all outputs are 0 and the FSM is in IDLE; no further plots; a subsequent `start` draws normally.
